// File: rtl/drawunit_wr_responder_if.sv
// Drawer/frame-buffer signal bundle for drawunit_wr_responder; master drives requests and sink status.
// Combinational wires only: no latency of its own, and backpressure is carried by mem_ready.
interface drawunit_wr_responder_if;
  logic        write_burst_req;
  logic [21:0] addr;
  logic [9:0]  write_burst_len;
  logic [15:0] rgb;
  logic        write_burst_data_req;
  logic        write_burst_data_finish;
  logic        mem_ready;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        err_oob;

  modport master (
    output write_burst_req, addr, write_burst_len, rgb, mem_ready,
    input  write_burst_data_req, write_burst_data_finish, mem_we, mem_addr, mem_wdata, busy, err_oob
  );

  modport slave (
    input  write_burst_req, addr, write_burst_len, rgb, mem_ready,
    output write_burst_data_req, write_burst_data_finish, mem_we, mem_addr, mem_wdata, busy, err_oob
  );
endinterface

// File: rtl/drawunit_wr_responder.sv
// Burst-write responder: one data_req per word, then a single-word frame-buffer write 2 cycles later; finish 3 cycles after the last req.
// mem_ready low holds off the next request for one cycle (at most 2 words in flight); WR_BOUND_CHECK_EN adds the FB_WORDS bound check.
module drawunit_wr_responder #(
  parameter logic [21:0] FB_WORDS = 22'd307200
) (
  input  logic                     clk,
  input  logic                     rst,
  drawunit_wr_responder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    DATA   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        issue;

  logic [21:0] cur_addr;
  logic [9:0]  remaining;
  logic        data_req;
  logic        req_d;
  logic        finish;
  logic        busy;
  logic        we;
  logic [21:0] waddr;
  logic [15:0] wdata;
  logic        in_bound;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.write_burst_req) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        if (remaining == 10'd0) begin
          state_nxt = FINISH;
        end else begin
          issue     = bus.mem_ready;
          state_nxt = (issue && remaining == 10'd1) ? DRAIN : DATA;
        end
      end
      DATA: begin
        issue = bus.mem_ready;
        if (issue && remaining == 10'd1) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Last mem_we is launched in the cycle the capture stage empties.
        if (!data_req && !req_d) state_nxt = FINISH;
      end
      FINISH:  state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef WR_BOUND_CHECK_EN
  logic err_oob;

  assign in_bound = (cur_addr < FB_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if (req_d && !in_bound) begin
      err_oob <= 1'b1;
    end
  end

  assign bus.err_oob = err_oob;
`else
  assign in_bound    = 1'b1;
  assign bus.err_oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      data_req  <= 1'b0;
      req_d     <= 1'b0;
      finish    <= 1'b0;
      busy      <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      data_req <= issue;
      req_d    <= data_req;
      finish   <= (state_nxt == FINISH);
      busy     <= (state_nxt != IDLE);
      we       <= 1'b0;

      if (state == IDLE && bus.write_burst_req) begin
        cur_addr  <= bus.addr;
        remaining <= bus.write_burst_len;
      end else if (issue) begin
        remaining <= remaining - 10'd1;
      end

      // rgb is valid the cycle after data_req; capture it with its address.
      if (req_d) begin
        waddr    <= cur_addr;
        wdata    <= bus.rgb;
        we       <= in_bound;
        cur_addr <= cur_addr + 22'd1;
      end
    end
  end

  assign bus.write_burst_data_req    = data_req;
  assign bus.write_burst_data_finish = finish;
  assign bus.busy                    = busy;
  assign bus.mem_we                  = we;
  assign bus.mem_addr                = waddr;
  assign bus.mem_wdata               = wdata;

endmodule

// File: tb/tb_drawunit_wr_responder.sv
// Directed bench for drawunit_wr_responder: cycle 0 is the cycle whose closing edge accepts the burst.
module tb_drawunit_wr_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  drawunit_wr_responder_if bus ();

  drawunit_wr_responder #(.FB_WORDS(22'd307200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          req_cyc[$];
  int          we_cyc[$];
  logic [21:0] we_addr[$];
  logic [15:0] we_data[$];
  int          fin_cyc;
  int          fin_cnt;
  int          busy_low;
  int          err_cyc;
  logic        rst_snap_zero;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request is raised in the current cycle (cycle 0); the loop samples outputs
  // 1 ns after each edge and then drives that cycle's inputs.
  task automatic run_burst(input logic [21:0] a, input logic [9:0] n,
                           input logic [15:0] rgb_base, input logic [15:0] rgb_step,
                           input int st_lo, input int st_hi, input int rst_at, input int budget);
    int   k;
    logic prev_req;
    req_cyc.delete();
    we_cyc.delete();
    we_addr.delete();
    we_data.delete();
    fin_cyc       = -1;
    fin_cnt       = 0;
    busy_low      = -1;
    err_cyc       = -1;
    rst_snap_zero = 1'b0;
    k             = 0;
    prev_req      = 1'b0;
    rst                 = 1'b0;
    bus.write_burst_req = 1'b1;
    bus.addr            = a;
    bus.write_burst_len = n;
    bus.mem_ready       = 1'b1;
    bus.rgb             = 16'hDEAD;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      if (bus.write_burst_data_req) req_cyc.push_back(cyc);
      if (bus.mem_we) begin
        we_cyc.push_back(cyc);
        we_addr.push_back(bus.mem_addr);
        we_data.push_back(bus.mem_wdata);
      end
      if (bus.write_burst_data_finish) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = cyc;
      end
      if (bus.err_oob && err_cyc < 0) err_cyc = cyc;
      if (!bus.busy && busy_low < 0 && fin_cyc >= 0) busy_low = cyc;
      if (cyc == rst_at + 1)
        rst_snap_zero = !bus.write_burst_data_req && !bus.write_burst_data_finish &&
                        !bus.mem_we && !bus.busy && !bus.err_oob &&
                        bus.mem_addr == 22'd0 && bus.mem_wdata == 16'd0;
      bus.rgb  = prev_req ? (rgb_base + rgb_step * 16'(k)) : 16'hDEAD;
      if (prev_req) k++;
      prev_req = bus.write_burst_data_req;
      bus.mem_ready = !(cyc >= st_lo && cyc <= st_hi);
      if (bus.write_burst_data_finish || cyc == rst_at) bus.write_burst_req = 1'b0;
      rst = (cyc == rst_at);
      // Sample-point-only inputs are scrambled to show later changes are ignored.
      bus.addr            = ~a;
      bus.write_burst_len = 10'h3FF;
    end
    bus.write_burst_req = 1'b0;
    bus.mem_ready       = 1'b1;
    rst                 = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.write_burst_req = 1'b0;
    bus.addr            = 22'd0;
    bus.write_burst_len = 10'd0;
    bus.rgb             = 16'd0;
    bus.mem_ready       = 1'b1;
    repeat (3) tick();
    chk("rst_data_req", bus.write_burst_data_req, 0);
    chk("rst_finish",   bus.write_burst_data_finish, 0);
    chk("rst_mem_we",   bus.mem_we, 0);
    chk("rst_busy",     bus.busy, 0);
    chk("rst_err_oob",  bus.err_oob, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    repeat (2) tick();

    // addr=100, len=4, constant pixel
    run_burst(22'd100, 10'd4, 16'hF800, 16'd0, 1000, 0, -1, 14);
    chk("t1_req_cnt", req_cyc.size(), 4);
    for (int i = 0; i < 4 && i < req_cyc.size(); i++) chk("t1_req_cyc", req_cyc[i], 2 + i);
    chk("t1_we_cnt", we_cyc.size(), 4);
    for (int i = 0; i < 4 && i < we_cyc.size(); i++) begin
      chk("t1_we_cyc",  we_cyc[i], 4 + i);
      chk("t1_we_addr", we_addr[i], 100 + i);
      chk("t1_we_data", we_data[i], 16'hF800);
    end
    chk("t1_fin_cyc",  fin_cyc, 8);
    chk("t1_fin_cnt",  fin_cnt, 1);
    chk("t1_busy_low", busy_low, 10);

    // zero-length burst
    run_burst(22'd5, 10'd0, 16'h1234, 16'd0, 1000, 0, -1, 8);
    chk("t2_req_cnt",  req_cyc.size(), 0);
    chk("t2_we_cnt",   we_cyc.size(), 0);
    chk("t2_fin_cyc",  fin_cyc, 2);
    chk("t2_busy_low", busy_low, 4);

    // len=8, mem_ready low in cycles 4..6
    run_burst(22'd200, 10'd8, 16'h1000, 16'd1, 4, 6, -1, 22);
    chk("t3_req_cnt", req_cyc.size(), 8);
    chk("t3_we_cnt",  we_cyc.size(), 8);
    for (int i = 0; i < 8 && i < we_addr.size(); i++) begin
      chk("t3_we_addr", we_addr[i], 200 + i);
      chk("t3_we_data", we_data[i], 16'h1000 + i);
    end
    if (we_cyc.size() == 8) chk("t3_last_we", we_cyc[7], 14);
    chk("t3_fin_cyc",  fin_cyc, 15);
    chk("t3_busy_low", busy_low, 17);

`ifdef WR_BOUND_CHECK_EN
    // crossing FB_WORDS: only the in-bound words are written
    run_burst(22'd307198, 10'd4, 16'h0A00, 16'd1, 1000, 0, -1, 14);
    chk("t4_req_cnt", req_cyc.size(), 4);
    chk("t4_we_cnt",  we_cyc.size(), 2);
    if (we_addr.size() >= 2) begin
      chk("t4_we_addr0", we_addr[0], 307198);
      chk("t4_we_addr1", we_addr[1], 307199);
    end
    chk("t4_err_cyc", err_cyc, 6);
    chk("t4_fin_cyc", fin_cyc, 8);
`else
    // address wrap at 2^22
    run_burst(22'h3FFFFE, 10'd4, 16'h0A00, 16'd1, 1000, 0, -1, 14);
    chk("t4_req_cnt", req_cyc.size(), 4);
    chk("t4_we_cnt",  we_cyc.size(), 4);
    if (we_addr.size() >= 4) begin
      chk("t4_we_addr0", we_addr[0], 22'h3FFFFE);
      chk("t4_we_addr1", we_addr[1], 22'h3FFFFF);
      chk("t4_we_addr2", we_addr[2], 22'h000000);
      chk("t4_we_addr3", we_addr[3], 22'h000001);
      chk("t4_we_data3", we_data[3], 16'h0A03);
    end
    chk("t4_err_cyc", err_cyc, -1);
    chk("t4_fin_cyc", fin_cyc, 8);
`endif

    // reset during cycle 4 of a len=16 burst
    run_burst(22'd1000, 10'd16, 16'h5500, 16'd1, 1000, 0, 4, 30);
    chk("t5_rst_zero", rst_snap_zero, 1);
    chk("t5_req_cnt",  req_cyc.size(), 3);
    chk("t5_we_cnt",   we_cyc.size(), 1);
    if (we_cyc.size() >= 1) chk("t5_we_cyc", we_cyc[0], 4);
    chk("t5_fin_cnt",  fin_cnt, 0);

    // normal burst after the abandoned one
    run_burst(22'd50, 10'd2, 16'h0777, 16'd1, 1000, 0, -1, 12);
    chk("t6_req_cnt", req_cyc.size(), 2);
    chk("t6_we_cnt",  we_cyc.size(), 2);
    if (we_addr.size() >= 2) begin
      chk("t6_we_addr0", we_addr[0], 50);
      chk("t6_we_addr1", we_addr[1], 51);
      chk("t6_we_data1", we_data[1], 16'h0778);
    end
    chk("t6_fin_cyc",  fin_cyc, 6);
    chk("t6_busy_low", busy_low, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
